fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch stage for the RISC-V pipeline. It replaces the fixed single-register PC/fetch path in front of the IF/ID pipe register. It owns the PC and issues in-order requests to a variable-latency instruction memory. Fetched instructions and their PCs are buffered in a DEPTH-entry queue feeding decode with a valid/ready handshake, and wrong-path fetches are discarded when execute redirects the PC.

---
 rtl/fetch_queue_unit_if.sv | 59 +++++
 rtl/fetch_queue_unit.sv | 116 +++++++++++
 tb/tb_fetch_queue_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_if.sv
// Fetch stage bundle: redirect inputs, imem request/response and the
// decode-side valid/ready handshake, with one modport per side.
interface fetch_queue_unit_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [1:0]      pc_src;
  logic [XLEN-1:0] target_pc;
  logic [XLEN-1:0] jalr_pc;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pc_plus4;
  logic [PW-1:0]   count;

  modport master (
    input  pc_src,
    input  target_pc,
    input  jalr_pc,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc,
    output dec_pc_plus4,
    output count
  );

  modport slave (
    output pc_src,
    output target_pc,
    output jalr_pc,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc,
    input  dec_pc_plus4,
    input  count
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests and
// buffers {pc, instr} in a ring feeding decode; redirects drop stale data.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst,
  fetch_queue_unit_if.master fq
);
  localparam int IW  = $clog2(DEPTH);
  localparam int PW  = IW + 1;
  localparam int PW1 = PW + 1;
  localparam logic [PW:0] DEP = PW1'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [PW-1:0]   r_alloc;
  logic [PW-1:0]   r_fill;
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_drop;
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [31:0]     r_instr [DEPTH];

  logic [PW-1:0]   w_count;
  logic [PW-1:0]   w_outst;
  logic [PW:0]     w_used;
  logic            w_credit;
  logic            w_redir;
  logic [XLEN-1:0] w_jalr_tgt;
  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_rsp_fill;
  logic            w_deq;
  logic [PW:0]     w_drop_sum;
  logic [PW-1:0]   w_drop_redir;
  logic [IW-1:0]   w_rd_idx;

  assign w_redir = (fq.pc_src == 2'b01)
                 || (fq.pc_src == 2'b10);
  assign w_count = r_alloc - r_rd;
  assign w_outst = r_alloc - r_fill;
  assign w_used  = {1'b0, w_count}
                 + {1'b0, r_drop};
  assign w_credit = w_used < DEP;
  assign w_jalr_tgt = fq.jalr_pc & ~XLEN'(1);

  assign fq.imem_req_valid = rst & w_credit
                           & ~w_redir;
  assign fq.imem_req_addr  = r_fetch_pc;
  assign w_req_fire = fq.imem_req_valid
                    & fq.imem_req_ready;

  // stale responses are burned off drop_cnt before any fill
  assign w_rsp_drop = rst & ~w_redir
                    & fq.imem_rsp_valid
                    & (r_drop != '0);
  assign w_rsp_fill = rst & ~w_redir
                    & fq.imem_rsp_valid
                    & (r_drop == '0)
                    & (w_outst != '0);

  assign w_rd_idx = r_rd[IW-1:0];
  assign fq.dec_valid = rst & ~w_redir
                      & (r_rd != r_fill);
  assign fq.dec_instr = r_instr[w_rd_idx];
  assign fq.dec_pc    = r_pc[w_rd_idx];
  assign fq.dec_pc_plus4 = r_pc[w_rd_idx]
                         + XLEN'(4);
  assign fq.count = w_count;
  assign w_deq = fq.dec_valid & fq.dec_ready;

  // a response landing in the redirect cycle is one fewer to drop
  assign w_drop_sum = {1'b0, r_drop}
                    + {1'b0, w_outst};
  always_comb begin
    w_drop_redir = PW'(w_drop_sum);
    if (fq.imem_rsp_valid && w_drop_sum != '0)
      w_drop_redir = PW'(w_drop_sum - PW1'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_alloc    <= '0;
      r_fill     <= '0;
      r_rd       <= '0;
      r_drop     <= '0;
    end else if (w_redir) begin
      r_fetch_pc <= (fq.pc_src == 2'b01)
                  ? fq.target_pc : w_jalr_tgt;
      r_alloc    <= '0;
      r_fill     <= '0;
      r_rd       <= '0;
      r_drop     <= w_drop_redir;
    end else begin
      if (w_req_fire) begin
        r_alloc    <= r_alloc + PW'(1);
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_rsp_drop)
        r_drop <= r_drop - PW'(1);
      if (w_rsp_fill)
        r_fill <= r_fill + PW'(1);
      if (w_deq)
        r_rd <= r_rd + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire)
      r_pc[r_alloc[IW-1:0]] <= r_fetch_pc;
    if (w_rsp_fill)
      r_instr[r_fill[IW-1:0]] <= fq.imem_rsp_data;
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with an in-order
// fixed-latency instruction memory model.
module tb_fetch_queue_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  fetch_queue_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq();

  fetch_queue_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fq(fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] f(input logic [31:0] a);
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc       = 0;
  int    mem_lat   = 1;
  bit    flush_req = 1'b1;
  bit    spur_req  = 1'b0;

  always @(posedge clk) begin
    if (flush_req) begin
      mq.delete();
      fq.imem_rsp_valid <= 1'b0;
      fq.imem_rsp_data  <= '0;
    end else begin
      if (fq.imem_req_valid && fq.imem_req_ready)
        mq.push_back('{a: fq.imem_req_addr, due: cyc + mem_lat});
      if (spur_req) begin
        fq.imem_rsp_valid <= 1'b1;
        fq.imem_rsp_data  <= 32'hDEADBEEF;
      end else if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        fq.imem_rsp_valid <= 1'b1;
        fq.imem_rsp_data  <= f(mq[0].a);
        void'(mq.pop_front());
      end else begin
        fq.imem_rsp_valid <= 1'b0;
      end
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_st(input string t, input logic rv,
                           input logic [31:0] ra, input logic dv,
                           input logic [31:0] dpc, input int cnt);
    chk({t, ".req_valid"}, 64'(fq.imem_req_valid), 64'(rv));
    if (rv)
      chk({t, ".req_addr"}, 64'(fq.imem_req_addr), 64'(ra));
    chk({t, ".dec_valid"}, 64'(fq.dec_valid), 64'(dv));
    if (dv) begin
      chk({t, ".dec_pc"}, 64'(fq.dec_pc), 64'(dpc));
      chk({t, ".dec_pc4"}, 64'(fq.dec_pc_plus4), 64'(dpc + 32'd4));
      chk({t, ".dec_instr"}, 64'(fq.dec_instr), 64'(f(dpc)));
    end
    chk({t, ".count"}, 64'(fq.count), 64'(cnt));
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset(input int lat);
    rst          = 1'b0;
    flush_req    = 1'b1;
    fq.pc_src    = 2'b00;
    mem_lat      = lat;
    next();
    next();
    #1;
    chk("rst.req_valid", 64'(fq.imem_req_valid), 64'd0);
    chk("rst.dec_valid", 64'(fq.dec_valid), 64'd0);
    chk("rst.count", 64'(fq.count), 64'd0);
    flush_req = 1'b0;
    rst       = 1'b1;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] ra;
    logic        dv;
    logic [31:0] dpc;
    int          cnt;
  } vec_t;

  vec_t tbl[8];
  int   nreq;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  0};
    tbl[1] = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0,  1};
    tbl[2] = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0,  2};
    tbl[3] = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4,  2};
    tbl[4] = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8,  2};
    tbl[5] = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12, 2};
    tbl[6] = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd16, 2};
    tbl[7] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd20, 2};

    rst               = 1'b0;
    fq.pc_src         = 2'b00;
    fq.target_pc      = '0;
    fq.jalr_pc        = '0;
    fq.imem_req_ready = 1'b1;
    fq.dec_ready      = 1'b1;

    // streaming with a 1-cycle memory
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      fq.dec_ready = tbl[i].rdy;
      #1;
      expect_st($sformatf("stream%0d", i), tbl[i].rv, tbl[i].ra,
                tbl[i].dv, tbl[i].dpc, tbl[i].cnt);
      next();
    end

    // decode stalled: queue fills to DEPTH then drains in order
    fq.dec_ready = 1'b0;
    do_reset(1);
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (fq.imem_req_valid && fq.imem_req_ready)
        nreq++;
      if (c < 4)
        expect_st($sformatf("fill%0d", c), 1'b1, 32'(4 * c),
                  c >= 2, 32'd0, c);
      else
        expect_st($sformatf("full%0d", c), 1'b0, 32'd0,
                  1'b1, 32'd0, 4);
      next();
    end
    chk("full.nreq", 64'(nreq), 64'd4);
    fq.dec_ready = 1'b1;
    #1; expect_st("drain0", 1'b0, 32'd0,  1'b1, 32'd0,  4); next();
    #1; expect_st("drain1", 1'b1, 32'd16, 1'b1, 32'd4,  3); next();
    #1; expect_st("drain2", 1'b1, 32'd20, 1'b1, 32'd8,  3); next();
    #1; expect_st("drain3", 1'b1, 32'd24, 1'b1, 32'd12, 3); next();

    // branch redirect with two requests in flight, 3-cycle memory
    do_reset(3);
    #1; expect_st("br0", 1'b1, 32'd0, 1'b0, 32'd0, 0); next();
    #1; expect_st("br1", 1'b1, 32'd4, 1'b0, 32'd0, 1); next();
    fq.pc_src    = 2'b01;
    fq.target_pc = 32'h100;
    #1; expect_st("br2", 1'b0, 32'd0, 1'b0, 32'd0, 2); next();
    fq.pc_src = 2'b00;
    #1; expect_st("br3", 1'b1, 32'h100, 1'b0, 32'd0, 0); next();
    #1; expect_st("br4", 1'b1, 32'h104, 1'b0, 32'd0, 1); next();
    #1; expect_st("br5", 1'b1, 32'h108, 1'b0, 32'd0, 2); next();
    #1; expect_st("br6", 1'b1, 32'h10C, 1'b0, 32'd0, 3); next();
    #1; expect_st("br7", 1'b0, 32'd0, 1'b1, 32'h100, 4); next();
    #1; expect_st("br8", 1'b1, 32'h110, 1'b1, 32'h104, 3); next();

    // jalr redirect with a response landing in the redirect cycle
    do_reset(2);
    #1; expect_st("jr0", 1'b1, 32'd0, 1'b0, 32'd0, 0); next();
    #1; expect_st("jr1", 1'b1, 32'd4, 1'b0, 32'd0, 1); next();
    fq.pc_src  = 2'b10;
    fq.jalr_pc = 32'h203;
    #1;
    chk("jr2.rsp_in_redirect", 64'(fq.imem_rsp_valid), 64'd1);
    expect_st("jr2", 1'b0, 32'd0, 1'b0, 32'd0, 2); next();
    fq.pc_src = 2'b00;
    #1; expect_st("jr3", 1'b1, 32'h202, 1'b0, 32'd0, 0); next();
    #1; expect_st("jr4", 1'b1, 32'h206, 1'b0, 32'd0, 1); next();
    #1; expect_st("jr5", 1'b1, 32'h20A, 1'b0, 32'd0, 2); next();
    #1; expect_st("jr6", 1'b1, 32'h20E, 1'b1, 32'h202, 3); next();
    #1; expect_st("jr7", 1'b1, 32'h212, 1'b1, 32'h206, 3); next();

    // reset with a full queue and two responses still in flight
    fq.dec_ready = 1'b0;
    do_reset(3);
    #1; expect_st("mr0", 1'b1, 32'd0,  1'b0, 32'd0, 0); next();
    #1; expect_st("mr1", 1'b1, 32'd4,  1'b0, 32'd0, 1); next();
    #1; expect_st("mr2", 1'b1, 32'd8,  1'b0, 32'd0, 2); next();
    #1; expect_st("mr3", 1'b1, 32'd12, 1'b0, 32'd0, 3); next();
    #1; expect_st("mr4", 1'b0, 32'd0,  1'b1, 32'd0, 4); next();
    #1; expect_st("mr5", 1'b0, 32'd0,  1'b1, 32'd0, 4);
    rst = 1'b0;
    #1;
    chk("mr5.rst_req_valid", 64'(fq.imem_req_valid), 64'd0);
    next();
    #1;
    chk("mr6.count", 64'(fq.count), 64'd0);
    chk("mr6.dec_valid", 64'(fq.dec_valid), 64'd0);
    rst = 1'b1;
    #1; expect_st("mr6", 1'b1, 32'd0,  1'b0, 32'd0, 0); next();
    #1; expect_st("mr7", 1'b1, 32'd4,  1'b0, 32'd0, 1); next();
    #1; expect_st("mr8", 1'b1, 32'd8,  1'b0, 32'd0, 2); next();
    #1; expect_st("mr9", 1'b1, 32'd12, 1'b0, 32'd0, 3); next();
    #1; expect_st("mr10", 1'b0, 32'd0, 1'b1, 32'd0, 4); next();

    // spurious response with nothing outstanding
    fq.dec_ready      = 1'b1;
    fq.imem_req_ready = 1'b0;
    do_reset(1);
    spur_req = 1'b1;
    #1; expect_st("sp0", 1'b1, 32'd0, 1'b0, 32'd0, 0); next();
    spur_req = 1'b0;
    #1;
    chk("sp1.rsp_valid", 64'(fq.imem_rsp_valid), 64'd1);
    expect_st("sp1", 1'b1, 32'd0, 1'b0, 32'd0, 0); next();
    #1; expect_st("sp2", 1'b1, 32'd0, 1'b0, 32'd0, 0);
    fq.imem_req_ready = 1'b1;
    next();
    #1; expect_st("sp3", 1'b1, 32'd4, 1'b0, 32'd0, 1); next();
    #1; expect_st("sp4", 1'b1, 32'd8, 1'b1, 32'd0, 2); next();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
